// File: rtl/hemaia_mem_pkg.sv
// hemaia_mem_pkg: shared types for the HeMAiA superbank arbiter.
// Provides the arbiter FSM states, arbitration modes and starve counter type.
package hemaia_mem_pkg;

    typedef enum logic {
        WIDE_PRIO   = 1'b0,
        NARROW_SLOT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_STRICT = 1'b0,
        ARB_FAIR   = 1'b1
    } arb_mode_e;

    localparam int unsigned StarveWidth = 8;

    typedef logic [StarveWidth-1:0] starve_cnt_t;

endpackage

// File: rtl/hemaia_mem_superbank_arbiter_if.sv
// hemaia_mem_superbank_arbiter_if: wide + N narrow request/response ports.
// master = requester side, slave = arbiter side; suffixes are arbiter-relative.
interface hemaia_mem_superbank_arbiter_if #(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned AddrWidth       = 10
);
    localparam int unsigned N = WideDataWidth / NarrowDataWidth;

    logic                             wide_req_valid_i;
    logic                             wide_req_ready_o;
    logic [AddrWidth-1:0]             wide_req_addr_i;
    logic                             wide_req_write_i;
    logic [WideDataWidth-1:0]         wide_req_data_i;
    logic [WideDataWidth/8-1:0]       wide_req_strb_i;
    logic                             wide_rsp_valid_o;
    logic [WideDataWidth-1:0]         wide_rsp_data_o;

    logic [N-1:0]                     narrow_req_valid_i;
    logic [N-1:0]                     narrow_req_ready_o;
    logic [N*AddrWidth-1:0]           narrow_req_addr_i;
    logic [N-1:0]                     narrow_req_write_i;
    logic [N*NarrowDataWidth-1:0]     narrow_req_data_i;
    logic [N*NarrowDataWidth/8-1:0]   narrow_req_strb_i;
    logic [N-1:0]                     narrow_rsp_valid_o;
    logic [N*NarrowDataWidth-1:0]     narrow_rsp_data_o;

    modport master (
        output wide_req_valid_i, wide_req_addr_i, wide_req_write_i,
        output wide_req_data_i, wide_req_strb_i,
        input  wide_req_ready_o, wide_rsp_valid_o, wide_rsp_data_o,
        output narrow_req_valid_i, narrow_req_addr_i, narrow_req_write_i,
        output narrow_req_data_i, narrow_req_strb_i,
        input  narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_data_o
    );

    modport slave (
        input  wide_req_valid_i, wide_req_addr_i, wide_req_write_i,
        input  wide_req_data_i, wide_req_strb_i,
        output wide_req_ready_o, wide_rsp_valid_o, wide_rsp_data_o,
        input  narrow_req_valid_i, narrow_req_addr_i, narrow_req_write_i,
        input  narrow_req_data_i, narrow_req_strb_i,
        output narrow_req_ready_o, narrow_rsp_valid_o, narrow_rsp_data_o
    );

endinterface

// File: rtl/hemaia_mem_rsp_tracker.sv
// hemaia_mem_rsp_tracker: MemLatency-deep shift register of per-cycle grants.
// Ports: clk_i, rst_ni, wide_sel_i/narrow_mask_i in, delayed wide_sel_o/narrow_mask_o.
module hemaia_mem_rsp_tracker #(
    parameter int unsigned MemLatency = 1,
    parameter int unsigned NumBanks   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wide_sel_i,
    input  logic [NumBanks-1:0] narrow_mask_i,
    output logic                wide_sel_o,
    output logic [NumBanks-1:0] narrow_mask_o
);

    typedef struct packed {
        logic                wide_sel;
        logic [NumBanks-1:0] narrow_mask;
    } rsp_tag_t;

    rsp_tag_t stage_q [MemLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(MemLatency); s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= {wide_sel_i, narrow_mask_i};
            for (int s = 1; s < int'(MemLatency); s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign wide_sel_o    = stage_q[MemLatency-1].wide_sel;
    assign narrow_mask_o = stage_q[MemLatency-1].narrow_mask;

endmodule

// File: rtl/hemaia_mem_superbank_arbiter.sv
// hemaia_mem_superbank_arbiter: wide vs N narrow ports onto N narrow SRAM banks.
// Ports: clk_i, rst_ni, bus (slave), bank_* SRAM side, narrow_slot_o status.
module hemaia_mem_superbank_arbiter
    import hemaia_mem_pkg::*;
#(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned AddrWidth       = 10,
    parameter int unsigned MemLatency      = 1,
    parameter arb_mode_e   ArbMode         = ARB_FAIR,
    parameter int unsigned MaxStarve       = 16,
    localparam int unsigned N  = WideDataWidth / NarrowDataWidth,
    localparam int unsigned SW = NarrowDataWidth / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    hemaia_mem_superbank_arbiter_if.slave bus,
    output logic [N-1:0]                 bank_cs_o,
    output logic [N-1:0]                 bank_we_o,
    output logic [N*AddrWidth-1:0]       bank_addr_o,
    output logic [N*SW-1:0]              bank_be_o,
    output logic [N*NarrowDataWidth-1:0] bank_wdata_o,
    input  logic [N*NarrowDataWidth-1:0] bank_rdata_i,
    output logic                         narrow_slot_o
);

    if (WideDataWidth % NarrowDataWidth != 0) begin : g_err_ratio
        $error("WideDataWidth must be a multiple of NarrowDataWidth");
    end
    if (MemLatency != 1 && MemLatency != 2) begin : g_err_lat
        $error("MemLatency must be 1 or 2");
    end
    if (MaxStarve < 2 || MaxStarve > 255) begin : g_err_starve
        $error("MaxStarve must be in 2..255");
    end

    arb_state_e  state_q;
    starve_cnt_t starve_q;

    logic         wide_gnt;
    logic [N-1:0] narrow_gnt;
    logic         narrow_blocked;
    logic         starve_hit;

    assign wide_gnt       = bus.wide_req_valid_i && (state_q == WIDE_PRIO);
    assign narrow_gnt     = wide_gnt ? '0 : bus.narrow_req_valid_i;
    assign narrow_blocked = wide_gnt && (|bus.narrow_req_valid_i);
    assign starve_hit     = narrow_blocked &&
                            (starve_q == starve_cnt_t'(MaxStarve - 1));

    // Strict mode never leaves reset values: FSM pinned to WIDE_PRIO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WIDE_PRIO;
            starve_q <= '0;
        end else if (ArbMode == ARB_FAIR) begin
            unique case (state_q)
                WIDE_PRIO: begin
                    if (starve_hit) begin
                        state_q  <= NARROW_SLOT;
                        starve_q <= '0;
                    end else if (narrow_blocked) begin
                        starve_q <= starve_q + 1'b1;
                    end else begin
                        starve_q <= '0;
                    end
                end
                NARROW_SLOT: begin
                    state_q  <= WIDE_PRIO;
                    starve_q <= '0;
                end
            endcase
        end
    end

    assign narrow_slot_o          = (state_q == NARROW_SLOT);
    assign bus.wide_req_ready_o   = wide_gnt;
    assign bus.narrow_req_ready_o = narrow_gnt;

    always_comb begin
        bank_cs_o    = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int k = 0; k < int'(N); k++) begin
            bank_cs_o[k] = wide_gnt || narrow_gnt[k];
            if (wide_gnt) begin
                bank_we_o[k] = bus.wide_req_write_i;
                bank_addr_o[k*AddrWidth +: AddrWidth] = bus.wide_req_addr_i;
                bank_be_o[k*SW +: SW] = bus.wide_req_strb_i[k*SW +: SW];
                bank_wdata_o[k*NarrowDataWidth +: NarrowDataWidth] =
                    bus.wide_req_data_i[k*NarrowDataWidth +: NarrowDataWidth];
            end else begin
                bank_we_o[k] = narrow_gnt[k] && bus.narrow_req_write_i[k];
                bank_addr_o[k*AddrWidth +: AddrWidth] =
                    bus.narrow_req_addr_i[k*AddrWidth +: AddrWidth];
                bank_be_o[k*SW +: SW] = bus.narrow_req_strb_i[k*SW +: SW];
                bank_wdata_o[k*NarrowDataWidth +: NarrowDataWidth] =
                    bus.narrow_req_data_i[k*NarrowDataWidth +: NarrowDataWidth];
            end
        end
    end

    hemaia_mem_rsp_tracker #(
        .MemLatency (MemLatency),
        .NumBanks   (N)
    ) u_rsp_tracker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wide_sel_i    (wide_gnt),
        .narrow_mask_i (narrow_gnt),
        .wide_sel_o    (bus.wide_rsp_valid_o),
        .narrow_mask_o (bus.narrow_rsp_valid_o)
    );

    assign bus.wide_rsp_data_o   = bank_rdata_i;
    assign bus.narrow_rsp_data_o = bank_rdata_i;

endmodule

// File: tb/tb_hemaia_mem_superbank_arbiter.sv
// tb_hemaia_mem_superbank_arbiter: drives two arbiters (fair/lat1, strict/lat2)
// with the same directed stimulus and checks both against a behavioural model.
module tb_hemaia_mem_superbank_arbiter;
    import hemaia_mem_pkg::*;

    localparam int NW = 64;
    localparam int WW = 512;
    localparam int AW = 10;
    localparam int N  = WW / NW;
    localparam int SB = NW / 8;
    localparam int MS = 16;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic            wv, ww;
    logic [AW-1:0]   wa;
    logic [WW-1:0]   wd;
    logic [WW/8-1:0] ws;
    logic [N-1:0]    nv, nw;
    logic [N*AW-1:0] na;
    logic [N*NW-1:0] nd;
    logic [N*SB-1:0] ns;

    logic            wr    [2];
    logic            wrv   [2];
    logic [WW-1:0]   wrd   [2];
    logic [N-1:0]    nr    [2];
    logic [N-1:0]    nrv   [2];
    logic [N*NW-1:0] nrd   [2];
    logic [N-1:0]    cs    [2];
    logic [N-1:0]    we    [2];
    logic [N*AW-1:0] ba    [2];
    logic [N*SB-1:0] be    [2];
    logic [N*NW-1:0] bw    [2];
    logic [N*NW-1:0] rdata [2];
    logic            slot  [2];

    int total = 0;
    int bad = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        hemaia_mem_superbank_arbiter_if #(
            .NarrowDataWidth(NW), .WideDataWidth(WW), .AddrWidth(AW)
        ) bus ();
        assign bus.wide_req_valid_i   = wv;
        assign bus.wide_req_addr_i    = wa;
        assign bus.wide_req_write_i   = ww;
        assign bus.wide_req_data_i    = wd;
        assign bus.wide_req_strb_i    = ws;
        assign bus.narrow_req_valid_i = nv;
        assign bus.narrow_req_addr_i  = na;
        assign bus.narrow_req_write_i = nw;
        assign bus.narrow_req_data_i  = nd;
        assign bus.narrow_req_strb_i  = ns;
        assign wr[d]  = bus.wide_req_ready_o;
        assign wrv[d] = bus.wide_rsp_valid_o;
        assign wrd[d] = bus.wide_rsp_data_o;
        assign nr[d]  = bus.narrow_req_ready_o;
        assign nrv[d] = bus.narrow_rsp_valid_o;
        assign nrd[d] = bus.narrow_rsp_data_o;

        hemaia_mem_superbank_arbiter #(
            .NarrowDataWidth (NW),
            .WideDataWidth   (WW),
            .AddrWidth       (AW),
            .MemLatency      (d + 1),
            .ArbMode         (d == 0 ? ARB_FAIR : ARB_STRICT),
            .MaxStarve       (MS)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_ni),
            .bus           (bus),
            .bank_cs_o     (cs[d]),
            .bank_we_o     (we[d]),
            .bank_addr_o   (ba[d]),
            .bank_be_o     (be[d]),
            .bank_wdata_o  (bw[d]),
            .bank_rdata_i  (rdata[d]),
            .narrow_slot_o (slot[d])
        );
    end

    // Read data each bank returns for a given word address.
    function automatic logic [NW-1:0] rdf(input int k, input logic [AW-1:0] a);
        logic [7:0] id;
        id = 8'hC0 + 8'(k);
        return {id, 46'h0, a};
    endfunction

    // Bank SRAM stand-ins: 1-cycle for instance 0, 2-cycle for instance 1.
    logic [NW-1:0] s1 [2][N];
    logic [NW-1:0] s2 [N];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            s1[0][k] <= rdf(k, ba[0][k*AW +: AW]);
            s1[1][k] <= rdf(k, ba[1][k*AW +: AW]);
            s2[k]    <= s1[1][k];
        end
    end
    always_comb begin
        rdata[0] = '0;
        rdata[1] = '0;
        for (int k = 0; k < N; k++) begin
            rdata[0][k*NW +: NW] = s1[0][k];
            rdata[1][k*NW +: NW] = s2[k];
        end
    end

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Model: streak = consecutive cycles the wide port won while narrow waited.
    int            streak [2];
    logic [N:0]    htag [2][2];
    logic [N-1:0]  hrd  [2][2];
    logic [AW-1:0] hadr [2][2][N];

    task automatic model_step(input int d);
        int            lat;
        logic          sl, wg;
        logic [N-1:0]  ng, ecs, ewe;
        logic [N:0]    rt;
        logic [AW-1:0] ea [N];
        logic [AW+SB+NW-1:0] eb, ab;
        lat = d + 1;
        if (!rst_ni) begin
            streak[d] = 0;
            for (int s = 0; s < 2; s++) begin
                htag[d][s] = '0;
                hrd[d][s]  = '0;
            end
        end
        sl = (d == 0) && (streak[d] == MS);
        wg = wv && !sl;
        ng = wg ? '0 : nv;
        for (int k = 0; k < N; k++) begin
            ecs[k] = wg || ng[k];
            ewe[k] = wg ? ww : (ng[k] && nw[k]);
            ea[k]  = wg ? wa : na[k*AW +: AW];
        end
        chk($sformatf("d%0d wide_ready", d), 512'(wr[d]), 512'(wg));
        chk($sformatf("d%0d narrow_ready", d), 512'(nr[d]), 512'(ng));
        chk($sformatf("d%0d narrow_slot", d), 512'(slot[d]), 512'(sl));
        chk($sformatf("d%0d bank_cs", d), 512'(cs[d]), 512'(ecs));
        chk($sformatf("d%0d bank_we", d), 512'(we[d]), 512'(ewe));
        for (int k = 0; k < N; k++) begin
            if (ecs[k]) begin
                ab = {ba[d][k*AW +: AW], be[d][k*SB +: SB], bw[d][k*NW +: NW]};
                eb = {ea[k],
                      wg ? ws[k*SB +: SB] : ns[k*SB +: SB],
                      wg ? wd[k*NW +: NW] : nd[k*NW +: NW]};
                chk($sformatf("d%0d bank%0d drive", d, k), 512'(ab), 512'(eb));
            end
        end
        rt = htag[d][lat-1];
        chk($sformatf("d%0d wide_rsp_valid", d), 512'(wrv[d]), 512'(rt[N]));
        chk($sformatf("d%0d narrow_rsp_valid", d), 512'(nrv[d]), 512'(rt[N-1:0]));
        for (int k = 0; k < N; k++) begin
            if (rt[N] && hrd[d][lat-1][k])
                chk($sformatf("d%0d wide_rsp_data%0d", d, k),
                    512'(wrd[d][k*NW +: NW]), 512'(rdf(k, hadr[d][lat-1][k])));
            if (rt[k] && hrd[d][lat-1][k])
                chk($sformatf("d%0d narrow_rsp_data%0d", d, k),
                    512'(nrd[d][k*NW +: NW]), 512'(rdf(k, hadr[d][lat-1][k])));
        end
        if (rst_ni) begin
            streak[d]  = (wg && nv != '0) ? streak[d] + 1 : 0;
            htag[d][1] = htag[d][0];
            hrd[d][1]  = hrd[d][0];
            hadr[d][1] = hadr[d][0];
            htag[d][0] = {wg, ng};
            hrd[d][0]  = ecs & ~ewe;
            hadr[d][0] = ea;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic clr();
        wv = 1'b0; ww = 1'b0; wa = '0; wd = '0; ws = '0;
        nv = '0; nw = '0; ns = '1;
        for (int k = 0; k < N; k++) begin
            na[k*AW +: AW] = AW'(k);
            nd[k*NW +: NW] = 64'hD0D0_0000_0000_0000 | 64'(k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int first, n_slot, n_w0, n_w1, n_r0, n_r1, n_n1, lastr;
        rst_ni = 1'b0;
        clr();
        @(negedge clk);
        chk("reset slot", 512'(slot[0]), 512'(0));
        chk("reset rsp", 512'({wrv[0], wrv[1], nrv[0], nrv[1]}), 512'(0));
        step();
        step();
        rst_ni = 1'b1;

        // Wide held 40 cycles, narrow[0] and narrow[3] waiting.
        wv = 1'b1;
        nv = 8'h09;
        for (int k = 0; k < N; k++) na[k*AW +: AW] = AW'(10'h100 + k);
        first = -1; n_slot = 0; n_w0 = 0; n_w1 = 0;
        n_r0 = 0; n_r1 = 0; n_n1 = 0;
        for (int i = 0; i < 44; i++) begin
            if (i == 40) begin
                wv = 1'b0;
                nv = '0;
            end
            wa = AW'(i);
            @(negedge clk);
            if (nr[0][3] && first < 0) first = i;
            if (i == 16) chk("slot blocks wide", 512'(wr[0]), 512'(0));
            n_slot += int'(slot[0]);
            n_w0 += int'(wr[0]);
            n_w1 += int'(wr[1]);
            n_r0 += int'(wrv[0]);
            n_r1 += int'(wrv[1]);
            n_n1 += int'(nr[1][0]);
            step();
        end
        chk("fair first narrow grant", 512'(first), 512'(16));
        chk("fair slot count", 512'(n_slot), 512'(2));
        chk("fair wide grants", 512'(n_w0), 512'(38));
        chk("fair wide rsps", 512'(n_r0), 512'(38));
        chk("strict wide grants", 512'(n_w1), 512'(40));
        chk("strict wide rsps", 512'(n_r1), 512'(40));
        chk("strict narrow grants", 512'(n_n1), 512'(0));
        idle(2);

        // Narrow drops for one cycle: starve count must restart.
        first = -1;
        for (int i = 0; i < 30; i++) begin
            wv = 1'b1;
            wa = AW'(10'h200 + i);
            nv = (i == 10) ? 8'h00 : 8'h20;
            @(negedge clk);
            if (nr[0][5] && first < 0) first = i;
            step();
        end
        chk("starve restart grant", 512'(first), 512'(27));
        idle(4);

        // All eight narrow ports read 0x10..0x17 together.
        nv = 8'hFF;
        for (int k = 0; k < N; k++) na[k*AW +: AW] = AW'(10'h10 + k);
        @(negedge clk);
        chk("all narrow d0", 512'(nr[0]), 512'(8'hFF));
        chk("all narrow d1", 512'(nr[1]), 512'(8'hFF));
        step();
        clr();
        @(negedge clk);
        chk("all narrow rsp d0", 512'(nrv[0]), 512'(8'hFF));
        chk("bank7 rdata d0", 512'(nrd[0][7*NW +: NW]), 512'(64'hC700_0000_0000_0017));
        step();
        @(negedge clk);
        chk("all narrow rsp d1", 512'(nrv[1]), 512'(8'hFF));
        chk("bank0 rdata d1", 512'(nrd[1][NW-1:0]), 512'(64'hC000_0000_0000_0010));
        step();
        idle(2);

        // Alternating wide read / narrow[2] (one narrow write mixed in).
        n_r1 = 0; first = -1; lastr = -1;
        for (int i = 0; i < 11; i++) begin
            clr();
            if (i < 8) begin
                if (i % 2 == 0) begin
                    wv = 1'b1;
                    wa = AW'(10'h40 + i);
                end else begin
                    nv = 8'h04;
                    nw[2] = (i == 3);
                    na[2*AW +: AW] = AW'(10'h80 + i);
                end
            end
            @(negedge clk);
            if (wrv[1] || nrv[1][2]) begin
                n_r1++;
                if (first < 0) first = i;
                lastr = i;
            end
            step();
        end
        chk("alt rsp count", 512'(n_r1), 512'(8));
        chk("alt first rsp", 512'(first), 512'(2));
        chk("alt last rsp", 512'(lastr), 512'(9));
        idle(1);

        // Wide write, top address, alternating byte-strobe pattern.
        ww = 1'b1;
        wv = 1'b1;
        wa = 10'h3FF;
        wd = {64{8'hA5}};
        ws = {4{16'h00FF}};
        @(negedge clk);
        chk("write be", 512'(be[0]), 512'({4{16'h00FF}}));
        chk("write wdata", bw[0], {64{8'hA5}});
        chk("write we", 512'(we[0]), 512'(8'hFF));
        chk("write addr", 512'(ba[0]), 512'({8{10'h3FF}}));
        step();
        clr();
        n_r0 = 0; n_r1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_r0 += int'(wrv[0]);
            n_r1 += int'(wrv[1]);
            step();
        end
        chk("write rsp d0", 512'(n_r0), 512'(1));
        chk("write rsp d1", 512'(n_r1), 512'(1));

        // Partial starve build-up, then reset right after a wide grant.
        for (int i = 0; i < 10; i++) begin
            wv = 1'b1;
            nv = 8'h02;
            wa = AW'(10'h300 + i);
            step();
        end
        rst_ni = 1'b0;
        clr();
        @(negedge clk);
        chk("mid reset slot", 512'(slot[0]), 512'(0));
        step();
        rst_ni = 1'b1;
        n_r0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_r0 += int'(wrv[0]) + int'(wrv[1]) + int'(|nrv[0]) + int'(|nrv[1]);
            step();
        end
        chk("no rsp after reset", 512'(n_r0), 512'(0));
        first = -1;
        for (int i = 0; i < 20; i++) begin
            wv = 1'b1;
            nv = 8'h02;
            wa = AW'(10'h280 + i);
            @(negedge clk);
            if (nr[0][1] && first < 0) begin
                first = i;
                chk("post reset slot flag", 512'(slot[0]), 512'(1));
            end
            step();
        end
        chk("post reset starve grant", 512'(first), 512'(16));
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
